scratchpad_stream: RTL and testbench

//   Parametrised dual-port scratchpad with a command-driven DMA engine on port A and a

---
 rtl/spad_pkg.sv | 21 ++
 rtl/spad_dpram.sv | 54 +++++
 rtl/scratchpad_stream.sv | 214 +++++++++++++++++++++
 tb/tb_scratchpad_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spad_pkg.sv
// Shared types and constants for the scratchpad stream engine.
//   spad_dir_e   : burst direction carried on cmd_dir
//   spad_state_e : DMA engine states
//   FIFO_DEPTH   : entries in the stream-out skid FIFO
package spad_pkg;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } spad_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } spad_state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/spad_dpram.sv
// Behavioural true dual-port RAM with a registered read on each port.
// Reads return the word as it was before any same-edge write (read-first).
// Each port writes per byte lane. Swap in a vendor macro here only.
// Ports:
//   clk_i                  clock
//   a_en_i / b_en_i        port access enable (read always, write when be set)
//   a_be_i / b_be_i        byte write enables
//   a_addr_i / b_addr_i    word address
//   a_din_i / b_din_i      write data
//   a_dout_o / b_dout_o    read data, valid the cycle after the access
module spad_dpram #(
  parameter int DEPTH      = 8192,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    a_en_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_din_i,
  output logic [DATA_WIDTH-1:0]   a_dout_o,
  input  logic                    b_en_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic [DATA_WIDTH-1:0]   b_din_i,
  output logic [DATA_WIDTH-1:0]   b_dout_o
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_dout_q;
  logic [DATA_WIDTH-1:0] b_dout_q;

  // Both ports share one process so the array has a single driver; port B
  // is written last, though the engine never lets both write one word at once.
  always_ff @(posedge clk_i) begin
    if (a_en_i) begin
      a_dout_q <= mem_q[a_addr_i];
      for (int b = 0; b < NB; b++) begin
        if (a_be_i[b]) mem_q[a_addr_i][8*b +: 8] <= a_din_i[8*b +: 8];
      end
    end
    if (b_en_i) begin
      b_dout_q <= mem_q[b_addr_i];
      for (int b = 0; b < NB; b++) begin
        if (b_be_i[b]) mem_q[b_addr_i][8*b +: 8] <= b_din_i[8*b +: 8];
      end
    end
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/scratchpad_stream.sv
// Dual-port scratchpad: port A is driven by a burst DMA engine (stream-in
// writes memory, stream-out reads memory through a 2-entry FIFO), port B is a
// byte-enabled compute port that runs independently of the engine.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cmd_valid/ready/dir/base/len/abort  burst command interface
//   s_data/s_valid/s_ready              inbound word stream
//   m_data/m_valid/m_ready/m_last       outbound word stream
//   busy, done, err                     engine status and one-cycle pulses
//   comp_en/be/addr/din                 compute access (be==0 means read)
//   comp_dout, comp_dout_valid          compute read data, one cycle later
module scratchpad_stream
  import spad_pkg::*;
#(
  parameter int DEPTH      = 8192,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [ADDR_WIDTH-1:0]   cmd_base,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_abort,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    comp_en,
  input  logic [DATA_WIDTH/8-1:0] comp_be,
  input  logic [ADDR_WIDTH-1:0]   comp_addr,
  input  logic [DATA_WIDTH-1:0]   comp_din,
  output logic [DATA_WIDTH-1:0]   comp_dout,
  output logic                    comp_dout_valid
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  spad_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  comp_rvalid_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      fifo_wptr_q, fifo_rptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic                  inflight_q, inflight_last_q;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last_word, collision, wr_fire, rd_issue, pop, abort_act;
  logic [2:0]            occupancy;
  logic [DATA_WIDTH-1:0] ram_a_dout, ram_b_dout;

  // Stream-out can only issue a read while the FIFO plus the read in flight
  // leaves a free slot; counting this cycle's pop keeps 1 word/cycle flowing.
  always_comb begin
    cur_addr  = base_q + ADDR_WIDTH'(count_q);
    last_word = (count_q == len_q - LEN_WIDTH'(1));
    collision = comp_en && (|comp_be) && (comp_addr == cur_addr);
    s_ready   = (state_q == WR) && !collision;
    wr_fire   = s_valid && s_ready;
    m_valid   = (fifo_cnt_q != '0);
    pop       = m_valid && m_ready;
    occupancy = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    rd_issue  = (state_q == RD) && (occupancy < 3'd2);
    abort_act = cmd_abort && (state_q != IDLE);
  end

  // Next-state logic; abort overrides whatever the active state decided.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            err_d = 1'b1;
          end else begin
            base_d  = cmd_base;
            len_d   = cmd_len;
            count_d = '0;
            state_d = (spad_dir_e'(cmd_dir) == DIR_OUT) ? RD : WR;
          end
        end
      end
      WR: begin
        // Writes complete at the handshake edge, so there is nothing to drain.
        if (wr_fire) begin
          count_d = count_q + LEN_WIDTH'(1);
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        if (rd_issue) begin
          count_d = count_q + LEN_WIDTH'(1);
          if (last_word) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q &&
            ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_act) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      comp_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      count_q       <= count_d;
      done_q        <= done_d;
      err_q         <= err_d;
      comp_rvalid_q <= comp_en && !(|comp_be);
    end
  end

  // Read pipeline and output FIFO; data returning from an aborted burst is
  // dropped by clearing the in-flight flag together with the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wptr_q     <= '0;
      fifo_rptr_q     <= '0;
      fifo_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (abort_act) begin
      fifo_wptr_q     <= '0;
      fifo_rptr_q     <= '0;
      fifo_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && last_word;
      if (inflight_q) begin
        fifo_data_q[fifo_wptr_q] <= ram_a_dout;
        fifo_last_q[fifo_wptr_q] <= inflight_last_q;
        fifo_wptr_q              <= fifo_wptr_q + PTR_W'(1);
      end
      if (pop) fifo_rptr_q <= fifo_rptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(inflight_q) - CNT_W'(pop);
    end
  end

  spad_dpram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i    (clk),
    .a_en_i   (wr_fire || rd_issue),
    .a_be_i   (wr_fire ? '1 : '0),
    .a_addr_i (cur_addr),
    .a_din_i  (s_data),
    .a_dout_o (ram_a_dout),
    .b_en_i   (comp_en),
    .b_be_i   (comp_be),
    .b_addr_i (comp_addr),
    .b_din_i  (comp_din),
    .b_dout_o (ram_b_dout)
  );

  assign m_data          = fifo_data_q[fifo_rptr_q];
  assign m_last          = m_valid && fifo_last_q[fifo_rptr_q];
  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign err             = err_q;
  assign comp_dout_valid = comp_rvalid_q;
  assign comp_dout       = comp_rvalid_q ? ram_b_dout : '0;

endmodule

// File: tb/tb_scratchpad_stream.sv
// Scoreboard bench for scratchpad_stream: stimulus tasks push expected words
// into queues from a sparse memory model, a monitor pops and compares them.
module tb_scratchpad_stream;
  localparam int DEPTH = 8192;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int AW    = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, cmd_abort = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] s_data = '0, m_data, comp_din = '0, comp_dout;
  logic          s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1, m_last;
  logic          busy, done, err, comp_en = 1'b0, comp_dout_valid;
  logic [3:0]    comp_be = '0;
  logic [AW-1:0] comp_addr = '0;

  int checks = 0;
  int failures = 0;
  int doneCount = 0;
  int errCount = 0;
  int readyMode = 0;

  logic [DW-1:0] refMem [int];
  logic [DW:0]   mQ [$];
  logic [DW-1:0] cQ [$];

  scratchpad_stream dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .err(err),
    .comp_en(comp_en), .comp_be(comp_be), .comp_addr(comp_addr),
    .comp_din(comp_din), .comp_dout(comp_dout), .comp_dout_valid(comp_dout_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                               input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Downstream ready pattern: 0 always on, 1 toggling, 2 random, 3 always off.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: counts pulses, checks outbound words, compute reads and hold behaviour.
  initial begin
    logic          holdPrev;
    logic [DW:0]   holdVal;
    logic [DW:0]   e;
    logic [DW-1:0] c;
    holdPrev = 1'b0;
    holdVal  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holdPrev = 1'b0;
      end else begin
        if (done) doneCount++;
        if (err) errCount++;
        if (holdPrev) begin
          checkOutput("m_hold_valid", 64'(m_valid), 64'(1));
          checkOutput("m_hold_data", 64'({m_last, m_data}), 64'(holdVal));
        end
        holdPrev = m_valid && !m_ready && !cmd_abort;
        holdVal  = {m_last, m_data};
        if (m_valid && m_ready) begin
          if (mQ.size() == 0) checkOutput("m_unexpected_word", 64'(m_data), 64'hDEAD_0000_0000);
          else begin
            e = mQ.pop_front();
            checkOutput("m_word", 64'({m_last, m_data}), 64'(e));
          end
        end
        if (comp_dout_valid) begin
          if (cQ.size() == 0) checkOutput("comp_unexpected_read", 64'(comp_dout), 64'hDEAD_0000_0000);
          else begin
            c = cQ.pop_front();
            checkOutput("comp_dout", 64'(comp_dout), 64'(c));
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic dir, input int base, input int len);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_base  = AW'(base);
    cmd_len   = LW'(len);
    @(negedge clk);
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic streamIn(input int base, input int len, input int maxWords, input bit seqData);
    int i;
    int cycles;
    int target;
    logic [DW-1:0] d;
    i = 0;
    cycles = 0;
    target = (len < maxWords) ? len : maxWords;
    d = seqData ? DW'(1) : $urandom;
    while (i < target && cycles < 1000) begin
      s_data  = d;
      s_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (s_valid && s_ready) begin
        refMem[(base + i) % DEPTH] = d;
        i++;
        d = seqData ? DW'(i + 1) : $urandom;
      end
      @(posedge clk); #1;
      cycles++;
    end
    s_valid = 1'b0;
    checkOutput("stream_in_words", 64'(i), 64'(target));
  endtask

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (!busy) break;
      k++;
    end
    if (k >= budget) checkOutput("idle_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wrBurst(input int base, input int len, input bit seqData);
    int d0;
    d0 = doneCount;
    applyStimulus(1'b0, base, len);
    streamIn(base, len, len, seqData);
    waitIdle(50);
    checkOutput("wr_done_once", 64'(doneCount - d0), 64'(1));
  endtask

  task automatic rdBurst(input int base, input int len, input bit checkLatency);
    int d0;
    int k;
    d0 = doneCount;
    for (int i = 0; i < len; i++)
      mQ.push_back({1'(i == len - 1), refMem[(base + i) % DEPTH]});
    applyStimulus(1'b1, base, len);
    if (checkLatency) begin
      k = 1;
      while (k < 10) begin
        @(negedge clk);
        if (m_valid) break;
        k++;
      end
      checkOutput("rd_first_valid_latency", 64'(k), 64'(3));
    end
    waitIdle(400);
    checkOutput("rd_drained", 64'(mQ.size()), 64'(0));
    checkOutput("rd_done_once", 64'(doneCount - d0), 64'(1));
  endtask

  task automatic compRead(input int addr);
    @(posedge clk); #1;
    comp_en   = 1'b1;
    comp_be   = 4'b0000;
    comp_addr = AW'(addr);
    cQ.push_back(refMem[addr]);
    @(posedge clk); #1;
    comp_en = 1'b0;
  endtask

  task automatic compWrite(input int addr, input logic [DW-1:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    comp_en   = 1'b1;
    comp_be   = be;
    comp_addr = AW'(addr);
    comp_din  = d;
    refMem[addr] = mergeBytes(refMem.exists(addr) ? refMem[addr] : '0, d, be);
    @(posedge clk); #1;
    comp_en = 1'b0;
    comp_be = 4'b0000;
  endtask

  initial begin
    int e0;
    int d0;
    int base;
    int len;
    logic [DW-1:0] dmaWord;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
    checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
    checkOutput("rst_pulses", 64'({done, err, m_last}), 64'(0));
    checkOutput("rst_comp", 64'({comp_dout_valid, comp_dout}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known pattern write then read back.
    wrBurst(16, 4, 1'b1);
    rdBurst(16, 4, 1'b1);

    // Address wrap through the top of memory.
    wrBurst(DEPTH - 2, 4, 1'b0);
    compRead(DEPTH - 2);
    compRead(DEPTH - 1);
    compRead(0);
    compRead(1);

    // Toggling downstream ready.
    wrBurst(100, 8, 1'b0);
    readyMode = 1;
    rdBurst(100, 8, 1'b0);
    readyMode = 0;

    // Compute write colliding with the DMA write address.
    d0 = doneCount;
    applyStimulus(1'b0, 32, 1);
    dmaWord   = $urandom;
    comp_en   = 1'b1;
    comp_be   = 4'b0101;
    comp_addr = AW'(32);
    comp_din  = $urandom;
    s_valid   = 1'b1;
    s_data    = dmaWord;
    @(negedge clk);
    checkOutput("collision_s_ready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    comp_en = 1'b0;
    comp_be = 4'b0000;
    @(negedge clk);
    checkOutput("retry_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    refMem[32] = dmaWord;
    waitIdle(20);
    checkOutput("collision_done", 64'(doneCount - d0), 64'(1));
    compRead(32);

    // Byte-lane merge on the compute port alone.
    compWrite(48, 32'h1122_3344, 4'b1111);
    compWrite(48, 32'hAABB_CCDD, 4'b0101);
    compRead(48);
    checkOutput("merge_model", 64'(refMem[48]), 64'h11BB_33DD);

    // Zero-length command.
    e0 = errCount;
    applyStimulus(1'b0, 200, 0);
    @(negedge clk);
    checkOutput("zero_len_err", 64'(err), 64'(1));
    for (int i = 0; i < 3; i++) begin
      checkOutput("zero_len_busy", 64'(busy), 64'(0));
      @(negedge clk);
    end
    checkOutput("zero_len_err_count", 64'(errCount - e0), 64'(1));

    // Abort while stream-out is stalled.
    wrBurst(300, 8, 1'b0);
    readyMode = 3;
    d0 = doneCount;
    for (int i = 0; i < 8; i++) mQ.push_back({1'(i == 7), refMem[300 + i]});
    applyStimulus(1'b1, 300, 8);
    repeat (6) @(negedge clk);
    checkOutput("stalled_m_valid", 64'(m_valid), 64'(1));
    @(posedge clk); #1;
    cmd_abort = 1'b1;
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_m_valid", 64'(m_valid), 64'(0));
    checkOutput("abort_err", 64'(err), 64'(1));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    mQ.delete();
    readyMode = 0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneCount - d0), 64'(0));

    // Asynchronous reset in the middle of a write burst.
    applyStimulus(1'b0, 500, 16);
    streamIn(500, 16, 5, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 600, 2);
    checkOutput("postrst_busy", 64'(busy), 64'(1));
    streamIn(600, 2, 2, 1'b0);
    waitIdle(20);
    for (int i = 0; i < 5; i++) compRead(500 + i);
    rdBurst(600, 2, 1'b0);

    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 12);
      wrBurst(base, len, 1'b0);
      readyMode = $urandom_range(0, 2);
      rdBurst(base, len, 1'b0);
      readyMode = 0;
      compRead((base + len - 1) % DEPTH);
    end

    repeat (4) @(posedge clk);
    checkOutput("comp_queue_empty", 64'(cQ.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got 1 expected 0");
    $fatal(1, "[TB] timeout");
  end

endmodule
